// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the
// memory itself. The arbiter uses the slave view; the environment (requesters
// plus memory model) uses the master view.
// Optional feature macro: DMEM_ARB_LOCK_EN adds the lock0/lock1 request qualifiers.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] wd0, wd1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
`ifdef DMEM_ARB_LOCK_EN
    logic          lock0, lock1;
`endif

    modport slave (
`ifdef DMEM_ARB_LOCK_EN
        input  lock0, lock1,
`endif
        input  req0, req1, we0, we1, a0, a1, wd0, wd1, mem_rd,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_we, mem_a, mem_wd
    );

    modport master (
`ifdef DMEM_ARB_LOCK_EN
        output lock0, lock1,
`endif
        output req0, req1, we0, we1, a0, a1, wd0, wd1, mem_rd,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (sync write, async
// read). Port 0 is the CPU load/store path, port 1 the DMA/debug loader.
// Grants are combinational from registered state; read data returns one
// cycle after the granted read.
// Optional feature macro: DMEM_ARB_LOCK_EN adds lock0/lock1 and an ownership
// FSM that keeps the grant on one port for up to MAX_LOCK consecutive grants.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef DMEM_ARB_LOCK_EN
    ,
    parameter int MAX_LOCK = 8
`endif
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    // last_gnt = 1 means port 1 was granted most recently, so port 0 wins
    // the next contention.
    logic          last_gnt;
    logic          g0, g1;
    logic          rd0, rd1;
    logic          vld0_p1, vld1_p1;
    logic [DW-1:0] rdata0_p1, rdata1_p1;
    logic [AW-1:0] mem_a_mux;
    logic [DW-1:0] mem_wd_mux;

`ifdef DMEM_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam int CW = $clog2(MAX_LOCK + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    // Ownership state and consecutive-grant counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grant decision plus ownership transitions; the acquiring grant counts
    // as the first of the MAX_LOCK allowed consecutive grants.
    always_comb begin
        g0        = 1'b0;
        g1        = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!reset) begin
            case (state)
                OWN0: begin
                    g0 = bus.req0;
                    if (!bus.req0 || !bus.lock0 || cnt == CW'(MAX_LOCK - 1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                OWN1: begin
                    g1 = bus.req1;
                    if (!bus.req1 || !bus.lock1 || cnt == CW'(MAX_LOCK - 1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    g0 = bus.req0 & (~bus.req1 | last_gnt);
                    g1 = bus.req1 & (~bus.req0 | ~last_gnt);
                    if (MAX_LOCK > 1) begin
                        if (g0 && bus.lock0) begin
                            state_nxt = OWN0;
                            cnt_nxt   = CW'(1);
                        end else if (g1 && bus.lock1) begin
                            state_nxt = OWN1;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
            endcase
        end
    end
`else
    // Round-robin grant: a lone requester wins at once, contention goes to
    // the port that was not granted last.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset) begin
            g0 = bus.req0 & (~bus.req1 | last_gnt);
            g1 = bus.req1 & (~bus.req0 | ~last_gnt);
        end
    end
`endif

    // Remember the most recently granted port; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (g0 || g1) begin
            last_gnt <= g1;
        end
    end

    // Memory drive mux: port 0 is the default so idle cycles present a0/wd0.
    always_comb begin
        mem_a_mux  = bus.a0;
        mem_wd_mux = bus.wd0;
        if (g1) begin
            mem_a_mux  = bus.a1;
            mem_wd_mux = bus.wd1;
        end
    end

    assign rd0 = g0 & ~bus.we0;
    assign rd1 = g1 & ~bus.we1;

    // Read return stage: capture async memory data at the granted edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld0_p1   <= 1'b0;
            vld1_p1   <= 1'b0;
            rdata0_p1 <= '0;
            rdata1_p1 <= '0;
        end else begin
            vld0_p1 <= rd0;
            vld1_p1 <= rd1;
            if (rd0) rdata0_p1 <= bus.mem_rd;
            if (rd1) rdata1_p1 <= bus.mem_rd;
        end
    end

    assign bus.gnt0    = g0;
    assign bus.gnt1    = g1;
    assign bus.mem_we  = (g0 & bus.we0) | (g1 & bus.we1);
    assign bus.mem_a   = mem_a_mux;
    assign bus.mem_wd  = mem_wd_mux;
    assign bus.rvalid0 = vld0_p1;
    assign bus.rvalid1 = vld1_p1;
    assign bus.rdata0  = rdata0_p1;
    assign bus.rdata1  = rdata1_p1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model (pending requests, a
// round-robin pointer and a word array standing in for memory contents).
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory instance seen by the arbiter: async read, write at the edge.
    logic [31:0] tbmem [0:63] = '{default: 32'h0};
    assign bus.mem_rd = tbmem[bus.mem_a[7:2]];
    always @(posedge clk) begin
        if (bus.mem_we) tbmem[bus.mem_a[7:2]] <= bus.mem_wd;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:63];
    bit          pend [2];
    bit          pwe [2];
    logic [31:0] pa [2];
    logic [31:0] pwd [2];
    int          last;
    bit          exp_rv [2];
    logic [31:0] exp_rd [2];
    logic        obs_g0, obs_g1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        pend[p] = 1'b1;
        pwe[p]  = we;
        pa[p]   = a;
        pwd[p]  = d;
    endtask

    task automatic drive();
        bus.req0 = pend[0];
        bus.we0  = pwe[0];
        bus.a0   = pa[0];
        bus.wd0  = pwd[0];
        bus.req1 = pend[1];
        bus.we1  = pwe[1];
        bus.a1   = pa[1];
        bus.wd1  = pwd[1];
`ifdef DMEM_ARB_LOCK_EN
        bus.lock0 = 1'b0;
        bus.lock1 = 1'b0;
`endif
    endtask

    // One clock cycle: starts and ends 1 time unit after a rising edge.
    task automatic step();
        int g;
        drive();
        #1;
        if (reset)                  g = -1;
        else if (pend[0] && pend[1]) g = 1 - last;
        else if (pend[0])           g = 0;
        else if (pend[1])           g = 1;
        else                        g = -1;
        obs_g0 = bus.gnt0;
        obs_g1 = bus.gnt1;
        check("gnt0", 32'(bus.gnt0), 32'(g == 0));
        check("gnt1", 32'(bus.gnt1), 32'(g == 1));
        check("mem_we", 32'(bus.mem_we), (g >= 0) ? 32'(pwe[g]) : 32'd0);
        check("mem_a", bus.mem_a, (g == 1) ? pa[1] : pa[0]);
        if (g >= 0 && pwe[g]) check("mem_wd", bus.mem_wd, pwd[g]);
        @(posedge clk);
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (reset) begin
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            last      = 1;
        end else if (g >= 0) begin
            if (pwe[g]) ref_mem[pa[g][7:2]] = pwd[g];
            else begin
                exp_rv[g] = 1'b1;
                exp_rd[g] = ref_mem[pa[g][7:2]];
            end
            last    = g;
            pend[g] = 1'b0;
        end
        #1;
        check("rvalid0", 32'(bus.rvalid0), 32'(exp_rv[0]));
        check("rdata0", bus.rdata0, exp_rd[0]);
        check("rvalid1", 32'(bus.rvalid1), 32'(exp_rv[1]));
        check("rdata1", bus.rdata1, exp_rd[1]);
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic lk(input bit r0, input bit l0, input bit r1, input bit l1,
                      input bit e0, input bit e1, input string tag);
        bus.req0 = r0; bus.lock0 = l0; bus.we0 = 1'b0; bus.a0 = 32'h0; bus.wd0 = 32'h0;
        bus.req1 = r1; bus.lock1 = l1; bus.we1 = 1'b0; bus.a1 = 32'h4; bus.wd1 = 32'h0;
        #1;
        check({tag, "_g0"}, 32'(bus.gnt0), 32'(e0));
        check({tag, "_g1"}, 32'(bus.gnt1), 32'(e1));
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pwe[p] = 1'b0; pa[p] = '0; pwd[p] = '0;
            exp_rv[p] = 1'b0; exp_rd[p] = '0;
        end
        last = 1;
        @(posedge clk);
        #1;

        // Reset holds off a pending request.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF);
        step();
        step();
        reset = 1'b0;

        // Write then read back on port 0.
        step();
        check("t1_wr_gnt0", 32'(obs_g0), 32'd1);
        issue(0, 1'b0, 32'h10, 32'h0);
        step();
        check("t1_rvalid0", 32'(bus.rvalid0), 32'd1);
        check("t1_rdata0", bus.rdata0, 32'hDEADBEEF);

        // Contention after reset alternates 0,1,0,1.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!pend[0]) issue(0, 1'b0, 32'h40, 32'h0);
            if (!pend[1]) issue(1, 1'b0, 32'h44, 32'h0);
            step();
            check("rr_seq", 32'(obs_g1), 32'(i % 2));
        end
        step();

        // Port 1 write wins (port 0 granted last), port 0 read follows.
        issue(1, 1'b1, 32'h20, 32'h12345678);
        issue(0, 1'b0, 32'h20, 32'h0);
        step();
        check("t3_wr_gnt1", 32'(obs_g1), 32'd1);
        step();
        check("t3_rd_gnt0", 32'(obs_g0), 32'd1);
        check("t3_rdata0", bus.rdata0, 32'h12345678);

        // Reset the cycle after a granted read.
        issue(0, 1'b0, 32'h10, 32'h0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t4_rvalid0", 32'(bus.rvalid0), 32'd0);
        check("t4_rdata0", bus.rdata0, 32'd0);
        issue(0, 1'b0, 32'h40, 32'h0);
        issue(1, 1'b0, 32'h44, 32'h0);
        step();
        check("t4_first_gnt0", 32'(obs_g0), 32'd1);
        step();

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 9) < 6)
                    issue(p, 1'($urandom_range(0, 1)),
                          32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
                          $urandom);
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
            reset = 1'b0;
        end

`ifdef DMEM_ARB_LOCK_EN
        // Forced release after MAX_LOCK consecutive port-1 grants.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        lk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "lock_c1");
        for (int i = 2; i <= 8; i++) lk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "lock_hold");
        lk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "lock_c9");

        // lock0 dropped on the third grant hands over to port 1.
        reset = 1'b1;
        step();
        reset = 1'b0;
        lk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "drop_c1");
        lk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "drop_c2");
        lk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "drop_c3");
        lk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "drop_c4");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
